// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single-port program/data RAM between the CPU port and the loader/debug port.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate grants under contention instead of fixed CPU priority.
module mem_bus_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic [DW-1:0] ld_rdata,
  output logic          ld_ack,
  output logic          readMem,
  output logic          wren,
  output logic [AW-1:0] address,
  output logic [DW-1:0] data,
  input  logic [DW-1:0] mem_rdata,
  input  logic          memDataReady,
  output logic          busy,
  output logic          timeout_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t        state, state_n;
  logic          readMem_n, wren_n, cpu_ack_n, ld_ack_n, busy_n, timeout_err_n;
  logic [AW-1:0] address_n;
  logic [DW-1:0] data_n, cpu_rdata_n, ld_rdata_n;
  logic          last_ld, last_ld_n;   // 1 = loader held the most recent grant
  logic          gnt_ld, gnt_ld_n;     // requester owning the current access
  logic [7:0]    wait_cnt, wait_cnt_n;
  logic          pick_ld;

`ifdef ARB_ROUND_ROBIN_EN
  assign pick_ld = ld_req && (!cpu_req || !last_ld);
`else
  assign pick_ld = ld_req && !cpu_req;
`endif

  always_ff @(posedge clk) begin
    if (Reset) begin
      state       <= IDLE;
      readMem     <= 1'b0;
      wren        <= 1'b0;
      cpu_ack     <= 1'b0;
      ld_ack      <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      address     <= '0;
      data        <= '0;
      cpu_rdata   <= '0;
      ld_rdata    <= '0;
      last_ld     <= 1'b1;
      gnt_ld      <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state       <= state_n;
      readMem     <= readMem_n;
      wren        <= wren_n;
      cpu_ack     <= cpu_ack_n;
      ld_ack      <= ld_ack_n;
      busy        <= busy_n;
      timeout_err <= timeout_err_n;
      address     <= address_n;
      data        <= data_n;
      cpu_rdata   <= cpu_rdata_n;
      ld_rdata    <= ld_rdata_n;
      last_ld     <= last_ld_n;
      gnt_ld      <= gnt_ld_n;
      wait_cnt    <= wait_cnt_n;
    end
  end

  always_comb begin
    state_n       = state;
    readMem_n     = readMem;
    wren_n        = wren;
    cpu_ack_n     = cpu_ack;
    ld_ack_n      = ld_ack;
    busy_n        = busy;
    timeout_err_n = timeout_err;
    address_n     = address;
    data_n        = data;
    cpu_rdata_n   = cpu_rdata;
    ld_rdata_n    = ld_rdata;
    last_ld_n     = last_ld;
    gnt_ld_n      = gnt_ld;
    wait_cnt_n    = wait_cnt;

    case (state)
      IDLE: begin
        if (cpu_req || ld_req) begin
          gnt_ld_n   = pick_ld;
          last_ld_n  = pick_ld;
          address_n  = pick_ld ? ld_addr  : cpu_addr;
          data_n     = pick_ld ? ld_wdata : cpu_wdata;
          readMem_n  = pick_ld ? !ld_we   : !cpu_we;
          wren_n     = pick_ld ? ld_we    : cpu_we;
          busy_n     = 1'b1;
          wait_cnt_n = '0;
          state_n    = ACCESS;
        end
      end
      ACCESS: begin
        // Ready takes precedence over a timeout landing in the same cycle.
        if (memDataReady) begin
          if (readMem) begin
            if (gnt_ld) ld_rdata_n  = mem_rdata;
            else        cpu_rdata_n = mem_rdata;
          end
          readMem_n = 1'b0;
          wren_n    = 1'b0;
          cpu_ack_n = !gnt_ld;
          ld_ack_n  = gnt_ld;
          state_n   = DONE;
        end else if (wait_cnt == CNT_LAST) begin
          if (readMem) begin
            if (gnt_ld) ld_rdata_n  = '1;
            else        cpu_rdata_n = '1;
          end
          readMem_n     = 1'b0;
          wren_n        = 1'b0;
          timeout_err_n = 1'b1;
          cpu_ack_n     = !gnt_ld;
          ld_ack_n      = gnt_ld;
          state_n       = DONE;
        end else begin
          wait_cnt_n = wait_cnt + 8'd1;
        end
      end
      DONE: begin
        cpu_ack_n = 1'b0;
        ld_ack_n  = 1'b0;
        busy_n    = 1'b0;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised scoreboard bench for mem_bus_arbiter with a RAM responder and transaction-level model.
module tb_mem_bus_arbiter;

  localparam int TMO = 15;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic        ld_req = 1'b0, ld_we = 1'b0;
  logic [15:0] ld_addr = '0, ld_wdata = '0;
  logic [15:0] ld_rdata;
  logic        ld_ack;
  logic        readMem, wren;
  logic [15:0] address, data;
  logic [15:0] mem_rdata = '0;
  logic        memDataReady = 1'b0;
  logic        busy, timeout_err;

  mem_bus_arbiter #(.AW(16), .DW(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_ack(ld_ack),
    .readMem(readMem), .wren(wren), .address(address), .data(data),
    .mem_rdata(mem_rdata), .memDataReady(memDataReady),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ld;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          strobes;
    logic [15:0] cpu_rd;
    logic [15:0] ld_rd;
    bit          terr;
  } exp_t;

  typedef struct {
    int          lat;
    logic [15:0] rd;
  } ram_t;

  exp_t exp_q[$];
  ram_t ram_q[$];

  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  bit          m_last_ld = 1'b1;
  logic [15:0] m_cpu_rd = '0, m_ld_rd = '0;
  bit          m_terr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_access(input bit ld, input bit we, input logic [15:0] addr,
                              input logic [15:0] wd, input int lat, input logic [15:0] rd);
    exp_t e;
    ram_t r;
    bit   to;
    to = (lat > TMO);
    if (!we) begin
      if (ld) m_ld_rd  = to ? 16'hFFFF : rd;
      else    m_cpu_rd = to ? 16'hFFFF : rd;
    end
    if (to) m_terr = 1'b1;
    m_last_ld = ld;
    e.ld = ld; e.we = we; e.addr = addr; e.wdata = wd;
    e.strobes = to ? TMO : lat;
    e.cpu_rd = m_cpu_rd; e.ld_rd = m_ld_rd; e.terr = m_terr;
    exp_q.push_back(e);
    r.lat = lat; r.rd = rd;
    ram_q.push_back(r);
  endtask

  task automatic settle_idle();
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_acks", {30'd0, cpu_ack, ld_ack}, 32'd0);
  endtask

  task automatic do_single(input bit ld, input bit we, input logic [15:0] addr,
                           input logic [15:0] wd, input int lat, input logic [15:0] rd,
                           input bit drop);
    bit got = 1'b0;
    model_access(ld, we, addr, wd, lat, rd);
    if (ld) begin ld_req = 1'b1; ld_we = we; ld_addr = addr; ld_wdata = wd; end
    else    begin cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (drop && (readMem || wren)) begin cpu_req = 1'b0; ld_req = 1'b0; end
      if ((ld && ld_ack) || (!ld && cpu_ack)) begin got = 1'b1; break; end
    end
    if (!got) chk("single_ack_seen", 32'd0, 32'd1);
    cpu_req = 1'b0; ld_req = 1'b0;
    settle_idle();
  endtask

  // Both requesters held for n back-to-back grants; the model predicts the winner order.
  task automatic do_contend(input int n, input bit cwe, input logic [15:0] caddr, input logic [15:0] cwd,
                            input bit lwe, input logic [15:0] laddr, input logic [15:0] lwd);
    int acks = 0;
    for (int k = 0; k < n; k++) begin
      bit win_ld;
      win_ld = RR ? !m_last_ld : 1'b0;
      if (win_ld) model_access(1'b1, lwe, laddr, lwd, $urandom_range(1, 3), 16'($urandom));
      else        model_access(1'b0, cwe, caddr, cwd, $urandom_range(1, 3), 16'($urandom));
    end
    cpu_req = 1'b1; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    ld_req  = 1'b1; ld_we  = lwe; ld_addr  = laddr; ld_wdata  = lwd;
    for (int c = 0; c < 400 && acks < n; c++) begin
      @(negedge clk);
      if (cpu_ack || ld_ack) acks++;
    end
    if (acks < n) chk("contend_acks_seen", acks, n);
    cpu_req = 1'b0; ld_req = 1'b0;
    settle_idle();
  endtask

  // RAM responder: ready after the queued latency; noise on ready/rdata whenever no strobe is up.
  bit   r_active = 1'b0;
  int   r_cnt = 0;
  ram_t r_cur = '{lat: 0, rd: '0};
  always @(negedge clk) begin
    if (readMem || wren) begin
      if (!r_active) begin
        r_active = 1'b1;
        r_cnt = 0;
        if (ram_q.size() > 0) r_cur = ram_q.pop_front();
        else r_cur = '{lat: 0, rd: '0};
      end
      r_cnt++;
      memDataReady = (r_cnt == r_cur.lat);
      mem_rdata = (r_cnt == r_cur.lat) ? r_cur.rd : 16'($urandom);
    end else begin
      r_active = 1'b0;
      memDataReady = 1'($urandom_range(0, 1));
      mem_rdata = 16'($urandom);
    end
  end

  // Monitor: pops one expectation per acknowledge.
  int s_cnt = 0;
  bit saw_rd = 1'b0, saw_wr = 1'b0;
  always @(negedge clk) begin
    if (!busy) begin s_cnt = 0; saw_rd = 1'b0; saw_wr = 1'b0; end
    if (readMem || wren) begin
      s_cnt++;
      saw_rd |= readMem;
      saw_wr |= wren;
    end
    if (!Reset && (cpu_ack || ld_ack)) begin
      exp_t e;
      chk("ack_onehot", {30'd0, cpu_ack, ld_ack} & 32'd3, cpu_ack ? 32'd2 : 32'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("grant_owner", {31'd0, ld_ack}, {31'd0, e.ld});
        chk("strobe_cycles", s_cnt, e.strobes);
        chk("strobe_kind", {30'd0, saw_wr, saw_rd}, e.we ? 32'd2 : 32'd1);
        chk("address", {16'd0, address}, {16'd0, e.addr});
        if (e.we) chk("wdata", {16'd0, data}, {16'd0, e.wdata});
        chk("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, e.cpu_rd});
        chk("ld_rdata", {16'd0, ld_rdata}, {16'd0, e.ld_rd});
        chk("timeout_err", {31'd0, timeout_err}, {31'd0, e.terr});
        chk("busy_done", {31'd0, busy}, 32'd1);
      end
      s_cnt = 0; saw_rd = 1'b0; saw_wr = 1'b0;
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_outs"}, {27'd0, readMem, wren, cpu_ack, ld_ack, busy}, 32'd0);
    chk({tag, "_terr"}, {31'd0, timeout_err}, 32'd0);
    chk({tag, "_addr_data"}, {address, data}, 32'd0);
    chk({tag, "_rdata"}, {cpu_rdata, ld_rdata}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    Reset = 1'b0;

    // CPU read, ready in first ACCESS cycle
    do_single(1'b0, 1'b0, 16'h0010, 16'h0000, 1, 16'hBEEF, 1'b0);
    // Loader write, ready after 3 cycles
    do_single(1'b1, 1'b1, 16'h0020, 16'h1234, 3, 16'h0000, 1'b0);
    // Four contended reads
    do_contend(4, 1'b0, 16'h0100, 16'h0, 1'b0, 16'h0200, 16'h0);
    // Read that never sees ready
    do_single(1'b0, 1'b0, 16'h0040, 16'h0000, 100, 16'h1111, 1'b0);
    // Ready exactly on the last allowed cycle
    do_single(1'b1, 1'b0, 16'h0044, 16'h0000, TMO, 16'h2222, 1'b0);

    // Reset in the middle of a loader write
    begin
      ram_t r;
      r.lat = 100; r.rd = '0;
      ram_q.push_back(r);
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0030; ld_wdata = 16'h5555;
      repeat (4) @(negedge clk);
      chk("pre_reset_wren", {31'd0, wren}, 32'd1);
      Reset = 1'b1; ld_req = 1'b0;
      @(negedge clk);
      chk_reset_state("midreset");
      Reset = 1'b0;
      m_last_ld = 1'b1; m_cpu_rd = '0; m_ld_rd = '0; m_terr = 1'b0;
    end
    do_single(1'b0, 1'b0, 16'h0050, 16'h0000, 2, 16'hCAFE, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 150; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 3)
        do_contend($urandom_range(1, 3), 1'($urandom), 16'($urandom), 16'($urandom),
                   1'($urandom), 16'($urandom), 16'($urandom));
      else
        do_single(kind == 1, 1'($urandom), 16'($urandom), 16'($urandom),
                  $urandom_range(1, TMO + 2), 16'($urandom), $urandom_range(0, 3) == 0);
    end

    repeat (5) @(negedge clk);
    chk("exp_queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single-port program/data RAM between two requesters: the CPU memory port and a loader/debug port that preloads program images or dumps memory.
- Serialises accesses, drives the RAM control strobes and address/write-data, and waits on the RAM ready handshake.
- Returns read data and a one-cycle acknowledge to the granted requester; sits between cpu/loader and RAM in the top level, on the core clock.

Parameters:
AW, 16, address width
DW, 16, data width
TIMEOUT, 15, max ACCESS cycles waiting for memDataReady before abort (1..255)

Ports:
clk  in  1  core clock; all logic on rising edge
Reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request; held high until cpu_ack
cpu_we  in  1  1=write, 0=read; valid with cpu_req
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_rdata  out  DW  read data to CPU
cpu_ack  out  1  one-cycle completion pulse to CPU
ld_req  in  1  loader request; held high until ld_ack
ld_we  in  1  loader write enable
ld_addr  in  AW  loader address
ld_wdata  in  DW  loader write data
ld_rdata  out  DW  read data to loader
ld_ack  out  1  one-cycle completion pulse to loader
readMem  out  1  RAM read strobe
wren  out  1  RAM write strobe
address  out  AW  RAM address
data  out  DW  RAM write data
mem_rdata  in  DW  RAM read data
memDataReady  in  1  RAM access-complete indication
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky flag; set on any timed-out access

Behaviour:
- State machine states: IDLE, ACCESS, DONE. All outputs registered.
- Reset (synchronous, any state): state=IDLE; readMem, wren, cpu_ack, ld_ack, busy and timeout_err = 0; address, data, cpu_rdata and ld_rdata = 0; last_grant=loader. An in-flight access is abandoned with no ack.
- IDLE:
  - If any req is high: select a winner; latch its we, addr and wdata into address/data; set readMem=~we, wren=we and busy=1; clear the wait counter; go to ACCESS.
  - Fixed priority: CPU beats loader.
- ACCESS:
  - Strobes and address are held stable.
  - Counter increments each cycle memDataReady=0.
  - memDataReady=1: on a read, capture mem_rdata into the winner's rdata register. Drop the strobes, pulse the winner's ack, go to DONE.
  - Counter reaches TIMEOUT with no ready: drop the strobes, set timeout_err, load the winner's rdata with all-ones on a read. Ack the winner anyway and go to DONE.
- DONE (1 cycle): ack returns to 0, busy=0, state goes to IDLE. A request still high in DONE is ignored. Re-arbitration occurs in the following IDLE cycle, so there is always at least one IDLE cycle between grants.
- Latency:
  - req seen at edge 0, ACCESS from edge 1.
  - memDataReady high in the first ACCESS cycle gives ack high in the cycle after edge 2.
  - Minimum request-to-request throughput is 3 cycles.
- rdata registers hold their value until the next completed read by the same requester. The non-granted requester's outputs never change.
- The ack goes only to the granted requester; cpu_ack and ld_ack are never high together.
- A requester dropping req mid-access has no effect; the access completes and the ack is still pulsed.
- memDataReady is ignored in IDLE and DONE.
- last_grant updates on every grant.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: when both reqs are high in IDLE, the requester that is not last_grant wins. A lone request always wins. After reset the CPU wins the first contention (last_grant=loader).
- Undefined: fixed CPU priority. last_grant is still maintained but does not affect selection.

Test Plan:
- CPU read, addr 0x0010, RAM returns 0xBEEF with memDataReady in the first ACCESS cycle -> readMem=1 for 1 cycle, address=0x0010, cpu_rdata=0xBEEF, cpu_ack 1-cycle pulse 2 cycles after grant, ld_ack=0.
- Loader write, addr 0x0020, wdata 0x1234, ready after 3 cycles -> wren=1 for 3 cycles with data=0x1234, ld_ack pulse, then busy=0.
- cpu_req and ld_req high together for 4 transactions:
  - Fixed priority (ARB_ROUND_ROBIN_EN undefined): all four go to CPU.
  - ARB_ROUND_ROBIN_EN defined: grant order CPU, LD, CPU, LD.
- CPU read with memDataReady never asserted, TIMEOUT=15 -> strobe drops after 15 ACCESS cycles, cpu_rdata=0xFFFF, cpu_ack pulse, timeout_err=1 and held until Reset.
- Reset asserted mid-ACCESS of a loader write -> next cycle: IDLE, wren=0, busy=0, no ld_ack. A subsequent CPU read completes normally.
